// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared state encoding and saturating arithmetic for the LIF layer
// Purpose: FSM state type and a width-parametrised saturating signed add.
// Ports: none (package).
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRE  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest membrane the helper supports; callers sign-extend into this.
  localparam int SAT_MAXW = 32;

  // Adds two sign-extended operands and clamps the result to the signed
  // range of 'width' bits. One guard bit keeps the raw sum exact.
  function automatic logic signed [SAT_MAXW-1:0] sat_add(
    input logic signed [SAT_MAXW-1:0] a,
    input logic signed [SAT_MAXW-1:0] b,
    input int                         width
  );
    logic signed [SAT_MAXW:0] sum;
    logic signed [SAT_MAXW:0] hi;
    logic signed [SAT_MAXW:0] lo;
    sum = $signed({a[SAT_MAXW-1], a}) + $signed({b[SAT_MAXW-1], b});
    hi  = ((SAT_MAXW+1)'(1) <<< (width - 1)) - (SAT_MAXW+1)'(1);
    lo  = -((SAT_MAXW+1)'(1) <<< (width - 1));
    if (sum > hi)      return hi[SAT_MAXW-1:0];
    else if (sum < lo) return lo[SAT_MAXW-1:0];
    return sum[SAT_MAXW-1:0];
  endfunction

endpackage

// File: rtl/snn_lif_neuron.sv
// rtl/snn_lif_neuron.sv - one leaky integrate-and-fire neuron
// Purpose: membrane potential, refractory counter, accumulate/leak/fire.
// Ports: clk, reset (sync, active-high), clear (zero state), acc_en (add
//        weight this cycle), weight (signed WW), fire_en (one fire step),
//        spike (result of the last fire step).
module snn_lif_neuron
  import snn_pkg::*;
#(
  parameter int WW         = 8,
  parameter int VW         = 16,
  parameter int THRESH     = 64,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          acc_en,
  input  logic [WW-1:0] weight,
  input  logic          fire_en,
  output logic          spike
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic signed [VW-1:0] TH_V     = VW'(THRESH);
  localparam logic [RW-1:0]        REFRAC_V = RW'(REFRAC);

  logic signed [VW-1:0] v;
  logic signed [VW-1:0] v_acc;
  logic signed [VW-1:0] v_leak;
  logic [RW-1:0]        refrac;

  always_comb begin
    v_acc = VW'(sat_add(SAT_MAXW'(v), SAT_MAXW'($signed(weight)), VW));
    // A zero shift would subtract v from itself, so leak is bypassed.
    if (LEAK_SHIFT == 0) v_leak = v;
    else                 v_leak = v - (v >>> LEAK_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      v      <= '0;
      refrac <= '0;
      spike  <= 1'b0;
    end else if (acc_en) begin
      // Refractory neurons ignore input entirely.
      if (refrac == '0) v <= v_acc;
    end else if (fire_en) begin
      if (refrac != '0) begin
        refrac <= refrac - RW'(1);
        spike  <= 1'b0;
      end else if (v_leak >= TH_V) begin
        spike  <= 1'b1;
        v      <= '0;
        refrac <= REFRAC_V;
      end else begin
        spike  <= 1'b0;
        v      <= v_leak;
      end
    end
  end

endmodule

// File: rtl/snn_lif_layer.sv
// rtl/snn_lif_layer.sv - timestep sequencer for a layer of LIF neurons
// Purpose: FSM walking the weight rows of latched input spikes, then one
//          fire step, then publishing the spike vector with a done pulse.
// Ports: clk, reset (sync, active-high), start_en, clear_state, in_spikes,
//        w_addr/w_data (external weight memory, 1-cycle read latency),
//        busy, done, out_spikes.
module snn_lif_layer
  import snn_pkg::*;
#(
  parameter int N_IN       = 16,
  parameter int N_OUT      = 8,
  parameter int WW         = 8,
  parameter int VW         = 16,
  parameter int THRESH     = 64,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_en,
  input  logic                      clear_state,
  input  logic [N_IN-1:0]           in_spikes,
  output logic [$clog2(N_IN)-1:0]   w_addr,
  input  logic [N_OUT*WW-1:0]       w_data,
  output logic                      busy,
  output logic                      done,
  output logic [N_OUT-1:0]          out_spikes
);

  localparam int AW = $clog2(N_IN);
  localparam int IW = $clog2(N_IN + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN);

  state_t            state;
  logic [IW-1:0]     index;
  logic [N_IN-1:0]   spk_sh;
  logic [N_OUT-1:0]  fire_spk;
  logic              acc_en;
  logic              fire_en;
  logic              clear;

  // Weight data lags its address by one cycle, so the row seen at index k
  // belongs to input k-1; spk_sh[0] is kept aligned with that row.
  assign acc_en  = (state == ACCUM) && (index != '0) && spk_sh[0];
  assign fire_en = (state == FIRE);
  assign clear   = (state == IDLE) && clear_state;
  assign busy    = (state != IDLE);
  assign w_addr  = ((state == ACCUM) && (index != LAST_IDX)) ? index[AW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      spk_sh     <= '0;
      done       <= 1'b0;
      out_spikes <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_en && !clear_state) begin
            spk_sh <= in_spikes;
            index  <= '0;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          if (index != '0) spk_sh <= spk_sh >> 1;
          if (index == LAST_IDX) state <= FIRE;
          else                   index <= index + IW'(1);
        end
        FIRE: begin
          index <= '0;
          state <= DONE;
        end
        DONE: begin
          done       <= 1'b1;
          out_spikes <= fire_spk;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
    snn_lif_neuron #(
      .WW         (WW),
      .VW         (VW),
      .THRESH     (THRESH),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRAC     (REFRAC)
    ) u_neuron (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .acc_en  (acc_en),
      .weight  (w_data[j*WW +: WW]),
      .fire_en (fire_en),
      .spike   (fire_spk[j])
    );
  end

endmodule

// File: tb/tb_snn_lif_layer.sv
// tb/tb_snn_lif_layer.sv - bench for snn_lif_layer at VW=16 and VW=10
module tb_snn_lif_layer;

  localparam int N_IN  = 16;
  localparam int N_OUT = 8;
  localparam int WW    = 8;
  localparam int LAT   = N_IN + 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start_en;
  logic                  clear_state;
  logic [N_IN-1:0]       in_spikes;
  logic [3:0]            w_addr_a, w_addr_b;
  logic [N_OUT*WW-1:0]   w_data_a, w_data_b;
  logic                  busy_a, busy_b, done_a, done_b;
  logic [N_OUT-1:0]      out_a, out_b;

  int total = 0;
  int bad   = 0;

  int wmem [N_IN][N_OUT];
  int mv   [2][N_OUT];
  int mr   [2][N_OUT];

  always #5 clk = ~clk;

  snn_lif_layer dut_a (
    .clk(clk), .reset(reset), .start_en(start_en), .clear_state(clear_state),
    .in_spikes(in_spikes), .w_addr(w_addr_a), .w_data(w_data_a),
    .busy(busy_a), .done(done_a), .out_spikes(out_a)
  );

  snn_lif_layer #(.VW(10)) dut_b (
    .clk(clk), .reset(reset), .start_en(start_en), .clear_state(clear_state),
    .in_spikes(in_spikes), .w_addr(w_addr_b), .w_data(w_data_b),
    .busy(busy_b), .done(done_b), .out_spikes(out_b)
  );

  function automatic logic [N_OUT*WW-1:0] row(input logic [3:0] a);
    logic [N_OUT*WW-1:0] r;
    for (int j = 0; j < N_OUT; j++) r[j*WW +: WW] = 8'(wmem[a][j]);
    return r;
  endfunction

  // Weight memory with one cycle of read latency.
  always @(posedge clk) begin
    w_data_a <= row(w_addr_a);
    w_data_b <= row(w_addr_b);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: ideal integers clamped to the membrane range.
  function automatic int clamp(input int x, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic model_zero();
    for (int m = 0; m < 2; m++)
      for (int j = 0; j < N_OUT; j++) begin
        mv[m][j] = 0;
        mr[m][j] = 0;
      end
  endtask

  task automatic model_step(input logic [N_IN-1:0] sp, output logic [7:0] oa, output logic [7:0] ob);
    logic [7:0] o [2];
    int w, lv;
    for (int m = 0; m < 2; m++) begin
      w = (m == 0) ? 16 : 10;
      o[m] = '0;
      for (int j = 0; j < N_OUT; j++) begin
        if (mr[m][j] == 0)
          for (int i = 0; i < N_IN; i++)
            if (sp[i]) mv[m][j] = clamp(mv[m][j] + wmem[i][j], w);
        if (mr[m][j] > 0) begin
          mr[m][j] = mr[m][j] - 1;
        end else begin
          lv = mv[m][j] - (mv[m][j] >>> 3);
          if (lv >= 64) begin
            o[m][j]  = 1'b1;
            mv[m][j] = 0;
            mr[m][j] = 2;
          end else begin
            mv[m][j] = lv;
          end
        end
      end
    end
    oa = o[0];
    ob = o[1];
  endtask

  task automatic set_weights(input int base, input int step);
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) wmem[i][j] = base + step * j;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_state = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
    model_zero();
  endtask

  // Runs one timestep, checking w_addr sequence, busy, latency and pulse width.
  task automatic timestep(input logic [N_IN-1:0] sp, output logic [7:0] ga, output logic [7:0] gb);
    bit addr_ok, busy_ok;
    int lat, exp_addr;
    addr_ok = 1'b1;
    busy_ok = 1'b1;
    lat = -1;
    ga = '0;
    gb = '0;
    @(negedge clk);
    in_spikes = sp;
    start_en  = 1'b1;
    @(negedge clk);
    start_en  = 1'b0;
    in_spikes = N_IN'($urandom);
    for (int k = 0; k < 40 && lat < 0; k++) begin
      exp_addr = (k < N_IN) ? k : 0;
      if (int'(w_addr_a) != exp_addr || int'(w_addr_b) != exp_addr) addr_ok = 1'b0;
      if (k <= N_IN + 2 && !(busy_a && busy_b)) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      if (done_a) begin
        lat = k + 1;
        ga  = out_a;
        gb  = out_b;
        check("done_b_sync", int'(done_b), 1);
      end
    end
    check("latency", lat, LAT);
    check("w_addr_seq", int'(addr_ok), 1);
    check("busy_during", int'(busy_ok), 1);
    @(posedge clk);
    #1;
    check("done_pulse_width", int'(done_a | done_b), 0);
    check("held_out_a", int'(out_a), int'(ga));
  endtask

  typedef struct {
    bit          clr;
    logic [15:0] sp;
    int          wt;
    int          step;
    logic [7:0]  exp_a;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [7:0] ga, gb, ea, eb;
    int dones;

    tbl[0]  = '{1'b1, 16'h0003,   40, 0, 8'hFF};  // 80 -> 70 fires
    tbl[1]  = '{1'b0, 16'h0001,   40, 0, 8'h00};  // refractory
    tbl[2]  = '{1'b0, 16'h0001,   40, 0, 8'h00};  // refractory
    tbl[3]  = '{1'b0, 16'h0001,   40, 0, 8'h00};  // 40 -> 35
    tbl[4]  = '{1'b0, 16'h0001,   40, 0, 8'hFF};  // 75 -> 66 fires
    tbl[5]  = '{1'b0, 16'hFFFF,  127, 0, 8'h00};
    tbl[6]  = '{1'b0, 16'hFFFF,  127, 0, 8'h00};
    tbl[7]  = '{1'b0, 16'hFFFF,  127, 0, 8'hFF};
    tbl[8]  = '{1'b1, 16'h0000,   40, 0, 8'h00};
    tbl[9]  = '{1'b0, 16'hFFFF, -128, 0, 8'h00};  // -2048 (VW=10 clamps -512)
    tbl[10] = '{1'b0, 16'h00FF,  127, 0, 8'h00};  // VW=10 recovers and fires
    tbl[11] = '{1'b1, 16'h0001,   63, 0, 8'h00};  // 63 -> 56
    tbl[12] = '{1'b0, 16'h0000,   63, 0, 8'h00};  // 56 -> 49
    tbl[13] = '{1'b1, 16'h0001,   73, 0, 8'hFF};  // 73 -> 64, equal fires
    tbl[14] = '{1'b1, 16'h0001,   72, 0, 8'h00};  // 72 -> 63
    tbl[15] = '{1'b1, 16'h0003,   30, 6, 8'hFC};  // per-neuron weights

    reset = 1'b1;
    start_en = 1'b0;
    clear_state = 1'b0;
    in_spikes = '0;
    set_weights(0, 0);
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy_a | busy_b), 0);
    check("rst_done", int'(done_a | done_b), 0);
    check("rst_out", int'({out_a, out_b}), 0);
    check("rst_waddr", int'({w_addr_a, w_addr_b}), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 16; t++) begin
      if (tbl[t].clr) do_clear();
      set_weights(tbl[t].wt, tbl[t].step);
      model_step(tbl[t].sp, ea, eb);
      timestep(tbl[t].sp, ga, gb);
      check($sformatf("tbl%0d_out_a", t), int'(ga), int'(tbl[t].exp_a));
      check($sformatf("tbl%0d_out_b", t), int'(gb), int'(eb));
    end

    // Reset held two cycles mid-timestep after a firing step.
    do_clear();
    set_weights(40, 0);
    model_step(16'h0003, ea, eb);
    timestep(16'h0003, ga, gb);
    check("pre_rst_out", int'(ga), 8'hFF);
    @(negedge clk);
    in_spikes = 16'h0003;
    start_en = 1'b1;
    @(negedge clk);
    start_en = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_busy", int'(busy_a | busy_b), 0);
    check("midrst_done", int'(done_a | done_b), 0);
    check("midrst_out", int'({out_a, out_b}), 0);
    check("midrst_waddr", int'({w_addr_a, w_addr_b}), 0);
    reset = 1'b0;
    model_zero();
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done_a || busy_a) dones++;
    end
    check("midrst_no_done", dones, 0);
    model_step(16'h0000, ea, eb);
    timestep(16'h0000, ga, gb);
    check("post_rst_out_a", int'(ga), 0);
    check("post_rst_out_b", int'(gb), 0);

    // start_en during ACCUM is neither honoured nor queued.
    do_clear();
    set_weights(40, 0);
    model_step(16'h0003, ea, eb);
    @(negedge clk);
    in_spikes = 16'h0003;
    start_en = 1'b1;
    @(negedge clk);
    start_en = 1'b0;
    repeat (5) @(negedge clk);
    start_en = 1'b1;
    @(negedge clk);
    start_en = 1'b0;
    dones = 0;
    ga = '0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done_a) begin
        dones++;
        ga = out_a;
      end
    end
    check("busy_start_dones", dones, 1);
    check("busy_start_out", int'(ga), int'(ea));

    // clear_state beats start_en.
    @(negedge clk);
    start_en = 1'b1;
    clear_state = 1'b1;
    @(posedge clk);
    #1;
    check("clear_start_busy", int'(busy_a | busy_b), 0);
    @(negedge clk);
    start_en = 1'b0;
    clear_state = 1'b0;
    model_zero();

    // Randomized timesteps against the model.
    for (int r = 0; r < 24; r++) begin
      logic [N_IN-1:0] sp;
      if ($urandom_range(0, 5) == 0) do_clear();
      for (int i = 0; i < N_IN; i++)
        for (int j = 0; j < N_OUT; j++) wmem[i][j] = int'($urandom_range(0, 100)) - 30;
      sp = N_IN'($urandom);
      model_step(sp, ea, eb);
      timestep(sp, ga, gb);
      check($sformatf("rnd%0d_out_a", r), int'(ga), int'(ea));
      check($sformatf("rnd%0d_out_b", r), int'(gb), int'(eb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
